// File: rtl/fir_sym_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_sym_mac                                                    |
// | Purpose  : Symmetric odd-length FIR filter with one time-multiplexed     |
// |            pre-add / multiply / accumulate datapath, run-time loadable   |
// |            coefficients, valid/ready input and saturating output.        |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fir_sym_mac #(
  parameter int DATA_W = 18,
  parameter int COEF_W = 18,
  parameter int FRAC_W = 12,
  parameter int NTAPS  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              coef_we,
  input  logic [5:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data
);

  localparam int M      = (NTAPS + 1) / 2;          // unique coefficients
  localparam int KW     = $clog2(M);                // coefficient index width
  localparam int IW     = $clog2(NTAPS);            // delay-line index width
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(M);       // headroom for M products

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MAC  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] x_q [NTAPS];   // x_q[0] is the newest sample
  logic signed [COEF_W-1:0] c_q [M];
  logic [KW-1:0]            k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0]        out_data_q;
  logic                     out_valid_q;

  logic                     w_accept;
  logic                     w_centre;
  logic                     w_coef_wr;
  logic [IW-1:0]            w_near_idx;
  logic [IW-1:0]            w_far_idx;
  logic signed [DATA_W-1:0] w_near;
  logic signed [DATA_W-1:0] w_far;
  logic signed [PRE_W-1:0]  w_pre;
  logic signed [PROD_W-1:0] w_pre_x;
  logic signed [PROD_W-1:0] w_coef_x;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_final;
  logic signed [ACC_W-1:0]  w_shift;
  logic [DATA_W-1:0]        w_sat;

  assign w_accept   = in_valid && (state_q == S_IDLE);
  assign w_centre   = (k_q == KW'(M - 1));
  // Coefficients are frozen while a result is being computed.
  assign w_coef_wr  = coef_we && (state_q == S_IDLE) && (coef_addr < 6'(M));

  // Tap pair k and NTAPS-1-k share coefficient c[k].
  assign w_near_idx = IW'(k_q);
  assign w_far_idx  = IW'(NTAPS - 1) - IW'(k_q);
  assign w_near     = x_q[w_near_idx];
  assign w_far      = x_q[w_far_idx];

  // Centre tap has no partner, so it is not doubled.
  assign w_pre    = w_centre ? {w_near[DATA_W-1], w_near}
                             : ({w_near[DATA_W-1], w_near} + {w_far[DATA_W-1], w_far});
  assign w_pre_x  = {{(PROD_W-PRE_W){w_pre[PRE_W-1]}}, w_pre};
  assign w_coef_x = {{(PROD_W-COEF_W){c_q[k_q][COEF_W-1]}}, c_q[k_q]};
  assign w_prod   = w_pre_x * w_coef_x;
  assign w_final  = acc_q + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_shift  = w_final >>> FRAC_W;

  // Clamp the rescaled sum to the output sample range.
  always_comb begin
    w_sat = w_shift[DATA_W-1:0];
    if (w_shift > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_W-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: one accept starts M MAC steps, then back to IDLE.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_MAC;
      end
      S_MAC: begin
        if (w_centre) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Delay line, coefficient store, accumulator and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
      for (int i = 0; i < M; i++) c_q[i] <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (w_coef_wr) begin
        c_q[coef_addr[KW-1:0]] <= coef_data;
      end
      if (w_accept) begin
        x_q[0] <= in_data;
        for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
        acc_q <= '0;
        k_q   <= '0;
      end else if (state_q == S_MAC) begin
        acc_q <= w_final;
        k_q   <= k_q + KW'(1);
        if (w_centre) begin
          out_data_q  <= w_sat;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_sym_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fir_sym_mac                                                 |
// | Purpose  : Self-checking bench for fir_sym_mac against a direct-form     |
// |            convolution reference model.                                  |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fir_sym_mac;

  localparam int NT  = 11;
  localparam int M   = 6;
  localparam int DW  = 18;
  localparam int CW  = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          coef_we;
  logic [5:0]    coef_addr;
  logic [CW-1:0] coef_data;

  int checks = 0;
  int errors = 0;

  int hist [NT];   // reference delay line, hist[0] newest
  int cm   [M];    // reference coefficient store

  fir_sym_mac #(.DATA_W(DW), .COEF_W(CW), .FRAC_W(12), .NTAPS(NT)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain convolution over the full 11-tap impulse response.
  function automatic int golden();
    longint s;
    s = 0;
    for (int i = 0; i < NT; i++) begin
      s += longint'(hist[i]) * longint'(cm[(i < M) ? i : (NT - 1 - i)]);
    end
    s = s >>> 12;
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
    return int'(s);
  endfunction

  function automatic void model_accept(input int d);
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < NT; i++) hist[i] = 0;
    for (int i = 0; i < M; i++) cm[i] = 0;
  endtask

  task automatic wcoef(input int k, input int v);
    coef_we   = 1'b1;
    coef_addr = 6'(k);
    coef_data = CW'(v);
    step();
    coef_we = 1'b0;
    if (k < M) cm[k] = v;
  endtask

  // Accept one sample and wait (bounded) for its result; lat = cycles after accept edge.
  task automatic push(input int d, output int got, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    in_valid = 1'b1;
    in_data  = DW'(d);
    step();
    in_valid = 1'b0;
    model_accept(d);
    lat = -1;
    n   = 0;
    while (n < 50) begin
      if (out_valid) begin lat = n; break; end
      step();
      n++;
    end
    got = int'($signed(out_data));
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b required 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b required 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0d required 0", out_data); end
  endtask

  task automatic test_latency();
    int got, lat;
    in_valid = 1'b1;
    in_data  = DW'(5);
    step();
    in_valid = 1'b0;
    model_accept(5);
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if ({in_ready, out_valid} !== 2'b00) begin
        errors++;
        $display("FAIL lat_busy_cycle%0d got ready=%0b valid=%0b required 0 0", c, in_ready, out_valid);
      end
      step();
    end
    checks++;
    if ({in_ready, out_valid} !== 2'b11) begin
      errors++;
      $display("FAIL lat_cycle7 got ready=%0b valid=%0b required 1 1", in_ready, out_valid);
    end
    checks++;
    if (int'($signed(out_data)) !== golden()) begin
      errors++;
      $display("FAIL lat_first_data got %0d required %0d", $signed(out_data), golden());
    end
    push(9, got, lat);
    checks++;
    if (lat !== M) begin errors++; $display("FAIL lat_second got %0d required %0d", lat, M); end
  endtask

  task automatic test_impulse();
    int got, lat, exp;
    do_reset();
    for (int k = 0; k < M; k++) wcoef(k, (k == 0) ? 4096 : 0);
    for (int i = 0; i < 11; i++) begin
      push((i == 0) ? 100 : 0, got, lat);
      exp = (i == 0 || i == 10) ? 100 : 0;
      checks++;
      if (got !== exp || lat !== M) begin
        errors++;
        $display("FAIL impulse_c0_idx%0d got %0d (lat %0d) required %0d (lat %0d)", i, got, lat, exp, M);
      end
    end
    wcoef(0, 0);
    wcoef(5, 2048);
    for (int i = 0; i < 11; i++) begin
      push((i == 0) ? 100 : 0, got, lat);
      exp = (i == 5) ? 50 : 0;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL impulse_centre_idx%0d got %0d required %0d", i, got, exp);
      end
    end
  endtask

  task automatic test_symmetric();
    int got, lat, d, exp;
    int cs [M];
    cs = '{32'h050, 32'h1D3, 32'h041, 32'h0AE, 32'h2DB, 32'h9D0};
    for (int k = 0; k < M; k++) wcoef(k, cs[k]);
    for (int i = 0; i < 20; i++) begin
      d = int'($urandom_range(0, 262143)) - 131072;
      push(d, got, lat);
      exp = golden();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL symmetric_%0d got %0d required %0d", i, got, exp);
      end
    end
  endtask

  task automatic test_saturation();
    int got, lat;
    for (int k = 0; k < M; k++) wcoef(k, 4096);
    for (int i = 0; i < 11; i++) push(131071, got, lat);
    checks++;
    if (got !== 131071) begin errors++; $display("FAIL sat_pos got %0d required 131071", got); end
    for (int i = 0; i < 11; i++) push(-131072, got, lat);
    checks++;
    if (got !== -131072) begin errors++; $display("FAIL sat_neg got %0d required -131072", got); end
  endtask

  task automatic test_coef_rules();
    int got, lat, n, exp;
    for (int k = 0; k < M; k++) wcoef(k, (k == 0) ? 4096 : 0);
    // Write attempted during MAC must be ignored.
    in_valid = 1'b1;
    in_data  = DW'(1000);
    step();
    in_valid  = 1'b0;
    model_accept(1000);
    coef_we   = 1'b1;
    coef_addr = 6'd0;
    coef_data = CW'(32'h2000);
    step();
    step();
    coef_we = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    exp = golden();
    checks++;
    if (int'($signed(out_data)) !== exp || !out_valid) begin
      errors++;
      $display("FAIL coef_mac_write got %0d required %0d", $signed(out_data), exp);
    end
    push(2000, got, lat);
    exp = golden();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL coef_mac_write_after got %0d required %0d", got, exp); end
    // Out-of-range addresses must be ignored.
    wcoef(6, 32'h3000);
    wcoef(40, 32'h3000);
    push(1500, got, lat);
    exp = golden();
    checks++;
    if (got !== exp) begin errors++; $display("FAIL coef_addr_range got %0d required %0d", got, exp); end
    // Write and accept in the same IDLE cycle: new coefficient applies.
    coef_we   = 1'b1;
    coef_addr = 6'd0;
    coef_data = CW'(32'h0800);
    in_valid  = 1'b1;
    in_data   = DW'(3000);
    step();
    coef_we  = 1'b0;
    in_valid = 1'b0;
    cm[0] = 32'h0800;
    model_accept(3000);
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    exp = golden();
    checks++;
    if (int'($signed(out_data)) !== exp || !out_valid) begin
      errors++;
      $display("FAIL coef_write_with_accept got %0d required %0d", $signed(out_data), exp);
    end
  endtask

  task automatic test_reset_mid();
    int got, lat;
    bit seen;
    in_valid = 1'b1;
    in_data  = DW'(500);
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NT; i++) hist[i] = 0;
    for (int i = 0; i < M; i++) cm[i] = 0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_state got ready=%0b valid=%0b data=%0d required 1 0 0", in_ready, out_valid, out_data);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_valid got 1 required 0"); end
    push(100, got, lat);
    checks++;
    if (got !== 0 || lat !== M) begin
      errors++;
      $display("FAIL rst_mid_cleared_coef got %0d (lat %0d) required 0 (lat %0d)", got, lat, M);
    end
    wcoef(0, 4096);
    push(7, got, lat);
    checks++;
    if (got !== 7) begin errors++; $display("FAIL rst_mid_reload got %0d required 7", got); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    test_reset();
    test_latency();
    test_impulse();
    test_symmetric();
    test_saturation();
    test_coef_rules();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
